// File: rtl/ppi_bus_arbiter_if.sv
// Request/ack and i8255 register bus bundle shared by the CPU, the aux loader and the arbiter.
// slave = arbiter side, master = requester/PPI side.
interface ppi_bus_arbiter_if;
   logic       cpu_req;
   logic       cpu_we;
   logic [1:0] cpu_addr;
   logic [7:0] cpu_wdata;
   logic       cpu_ack;
   logic [7:0] cpu_rdata;
   logic       aux_req;
   logic       aux_we;
   logic [1:0] aux_addr;
   logic [7:0] aux_wdata;
   logic       aux_ack;
   logic [7:0] aux_rdata;
   logic       aux_lock;
   logic       ppi_cs_n;
   logic       ppi_rd_n;
   logic       ppi_wr_n;
   logic [1:0] ppi_a;
   logic [7:0] ppi_din;
   logic [7:0] ppi_dout;
   logic       busy;
   logic       grant_aux;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
      input  ppi_dout,
      output cpu_ack, cpu_rdata, aux_ack, aux_rdata,
      output ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_a, ppi_din,
      output busy, grant_aux
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output aux_req, aux_we, aux_addr, aux_wdata, aux_lock,
      output ppi_dout,
      input  cpu_ack, cpu_rdata, aux_ack, aux_rdata,
      input  ppi_cs_n, ppi_rd_n, ppi_wr_n, ppi_a, ppi_din,
      input  busy, grant_aux
   );
endinterface

// File: rtl/ppi_bus_arbiter.sv
// Shares one i8255 register port between the CPU and an aux loader, with SETUP/STROBE/RECOVER sequencing.
// Define PPI_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU wins every tie.
module ppi_bus_arbiter #(
   parameter int unsigned STROBE_CYCLES = 1,
   parameter int unsigned LOCK_MAX      = 64
) (
   input logic              clk,
   input logic              RESET,
   ppi_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

   localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
   localparam logic [7:0] LOCK_LAST   = 8'(LOCK_MAX - 1);

   state_t     state;
   logic       own_aux;
   logic       lat_we;
   logic [3:0] strobe_cnt;
   logic       locked;
   logic       cpu_owed;
   logic [7:0] lock_cnt;
`ifdef PPI_ARB_RR_EN
   logic       last_aux;
`endif

   logic       force_now;
   logic       lock_hold;
   logic       owed_eff;
   logic       cpu_elig;
   logic       aux_elig;
   logic       pick_aux;
   logic       lock_nxt;
   logic       owed_nxt;
   logic [7:0] cnt_nxt;

   // A forced release in this cycle already counts as owing the CPU, so aux cannot sneak one more grant in.
   assign force_now = locked && (lock_cnt == LOCK_LAST);
   assign lock_hold = locked && bus.aux_lock && !force_now;
   assign owed_eff  = cpu_owed || force_now;
   assign cpu_elig  = bus.cpu_req && !lock_hold;
   assign aux_elig  = bus.aux_req;

   always_comb begin
      pick_aux = 1'b0;
      if (aux_elig && !cpu_elig)
         pick_aux = 1'b1;
`ifdef PPI_ARB_RR_EN
      else if (aux_elig && cpu_elig && !owed_eff)
         pick_aux = !last_aux;
`endif
   end

   always_comb begin
      lock_nxt = locked;
      cnt_nxt  = lock_cnt;
      owed_nxt = cpu_owed;
      if (locked)
         cnt_nxt = lock_cnt + 8'd1;
      if (state == IDLE && locked && !bus.aux_lock) begin
         lock_nxt = 1'b0;
         cnt_nxt  = '0;
      end
      if (state == RECOVER && own_aux && bus.aux_lock && !cpu_owed && !locked) begin
         lock_nxt = 1'b1;
         cnt_nxt  = '0;
      end
      if (force_now) begin
         lock_nxt = 1'b0;
         cnt_nxt  = '0;
         owed_nxt = 1'b1;
      end
      if (state == IDLE && cpu_elig && !pick_aux)
         owed_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (RESET) begin
         state         <= IDLE;
         own_aux       <= 1'b0;
         lat_we        <= 1'b0;
         strobe_cnt    <= '0;
         locked        <= 1'b0;
         cpu_owed      <= 1'b0;
         lock_cnt      <= '0;
         bus.ppi_cs_n  <= 1'b1;
         bus.ppi_rd_n  <= 1'b1;
         bus.ppi_wr_n  <= 1'b1;
         bus.ppi_a     <= '0;
         bus.ppi_din   <= '0;
         bus.cpu_ack   <= 1'b0;
         bus.aux_ack   <= 1'b0;
         bus.cpu_rdata <= '0;
         bus.aux_rdata <= '0;
         bus.busy      <= 1'b0;
         bus.grant_aux <= 1'b0;
`ifdef PPI_ARB_RR_EN
         last_aux      <= 1'b1;
`endif
      end else begin
         locked      <= lock_nxt;
         lock_cnt    <= cnt_nxt;
         cpu_owed    <= owed_nxt;
         bus.cpu_ack <= 1'b0;
         bus.aux_ack <= 1'b0;
         case (state)
            IDLE: begin
               bus.grant_aux <= lock_nxt;
               if (cpu_elig || aux_elig) begin
                  state         <= SETUP;
                  own_aux       <= pick_aux;
                  lat_we        <= pick_aux ? bus.aux_we : bus.cpu_we;
                  bus.ppi_a     <= pick_aux ? bus.aux_addr : bus.cpu_addr;
                  bus.ppi_din   <= pick_aux ? bus.aux_wdata : bus.cpu_wdata;
                  bus.ppi_cs_n  <= 1'b0;
                  bus.busy      <= 1'b1;
                  bus.grant_aux <= pick_aux || lock_nxt;
`ifdef PPI_ARB_RR_EN
                  last_aux      <= pick_aux;
`endif
               end
            end
            SETUP: begin
               state         <= STROBE;
               strobe_cnt    <= '0;
               bus.ppi_rd_n  <= lat_we;
               bus.ppi_wr_n  <= !lat_we;
               bus.grant_aux <= own_aux || lock_nxt;
            end
            STROBE: begin
               bus.grant_aux <= own_aux || lock_nxt;
               if (strobe_cnt == STROBE_LAST) begin
                  state        <= RECOVER;
                  bus.ppi_cs_n <= 1'b1;
                  bus.ppi_rd_n <= 1'b1;
                  bus.ppi_wr_n <= 1'b1;
                  if (own_aux) begin
                     bus.aux_ack <= 1'b1;
                     if (!lat_we) bus.aux_rdata <= bus.ppi_dout;
                  end else begin
                     bus.cpu_ack <= 1'b1;
                     if (!lat_we) bus.cpu_rdata <= bus.ppi_dout;
                  end
               end else begin
                  strobe_cnt <= strobe_cnt + 4'd1;
               end
            end
            RECOVER: begin
               state         <= IDLE;
               bus.busy      <= 1'b0;
               bus.grant_aux <= lock_nxt;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
